// File: rtl/cone_eval_arbiter.sv
// Round-robin arbiter sharing one 5-input AOI cone between NUM_REQ requesters.
// Each accepted operand vector is registered, evaluated once, and returned on a
// valid/ready response channel that carries the requester id.
//
// state | meaning
// IDLE  | waiting for a request; req_ready is the one-hot round-robin grant
// EVAL  | cone evaluated from the registered operand into rsp_data / rsp_id
// RESP  | result presented; held until rsp_ready completes the handshake
module cone_eval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*5-1:0] req_vec,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_data,
  output logic                 busy,
  output logic [CNTW-1:0]      grant_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  localparam logic [IDW:0]   NUM_REQ_W = NUM_REQ[IDW:0];
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic [IDW:0]   cand;
  logic [4:0]     op_vec;
  logic [IDW-1:0] op_id;
  logic           accept;

  // Rotating priority search: first valid requester at or after ptr, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  assign accept    = (state == IDLE) && win_found;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // One-hot grant, only ever offered while idle.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[win_id] = 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, pointer advance, grant counting and cone evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      op_vec    <= '0;
      op_id     <= '0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
      grant_cnt <= '0;
    end else begin
      if (accept) begin
        op_vec <= req_vec[win_id*5 +: 5];
        op_id  <= win_id;
        ptr    <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
        if (grant_cnt != '1) begin
          grant_cnt <= grant_cnt + 1'b1;
        end
      end
      if (state == EVAL) begin
        rsp_id   <= op_id;
        rsp_data <= ~((op_vec[0] & op_vec[1] & op_vec[2]) | (op_vec[4] & ~op_vec[3]));
      end
    end
  end

endmodule

// File: tb/tb_cone_eval_arbiter.sv
// Bench for cone_eval_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a transaction-timing reference model.
module tb_cone_eval_arbiter;

  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N*5-1:0]    req_vec;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_data;
  logic              busy;
  logic [CNTW-1:0]   grant_cnt;

  cone_eval_arbiter #(.NUM_REQ(N), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_vec   (req_vec),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: block is either free, or holding one transaction whose
  // result becomes visible two cycles after its accept.
  bit m_free;
  int m_rsp_at;
  int m_id;
  bit m_data;
  int m_ptr;
  int m_cnt;
  int cyc = 0;
  int grant_log[$];
  int grant_cyc[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit cone_ref(input logic [4:0] v);
    return !((v[2:0] == 3'b111) || (v[4:3] == 2'b10));
  endfunction

  task automatic model_reset();
    m_free   = 1'b1;
    m_ptr    = 0;
    m_cnt    = 0;
    m_rsp_at = 0;
    m_id     = 0;
    m_data   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({pfx, "_rsp_id"},    32'(rsp_id),    32'd0);
    check({pfx, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({pfx, "_busy"},      32'(busy),      32'd0);
    check({pfx, "_grant_cnt"}, 32'(grant_cnt), 32'd0);
    check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N*5-1:0] vec, input logic rr);
    int g;
    logic [N-1:0] exp_rdy;
    bit exp_valid;
    @(negedge clk);
    req_valid = v;
    req_vec   = vec;
    rsp_ready = rr;
    #1;
    g = -1;
    if (m_free) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && v[i]) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_valid = !m_free && (cyc >= m_rsp_at);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("busy",      32'(busy),      32'(!m_free));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
    if (exp_valid) begin
      check("rsp_id",   32'(rsp_id),   32'(m_id));
      check("rsp_data", 32'(rsp_data), 32'(m_data));
    end
    if (g >= 0) begin
      m_free   = 1'b0;
      m_rsp_at = cyc + 2;
      m_id     = g;
      m_data   = cone_ref(vec[g*5 +: 5]);
      m_ptr    = (g + 1) % N;
      if (m_cnt < CMAX) m_cnt++;
      grant_log.push_back(g);
      grant_cyc.push_back(cyc);
    end else if (exp_valid && rr) begin
      m_free = 1'b1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    req_vec   = '0;
    rsp_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [N*5-1:0] rand_vec();
    return (N*5)'($urandom());
  endfunction

  logic [4:0] cone_vecs [5] = '{5'b00000, 5'b10000, 5'b11000, 5'b00011, 5'b11111};
  bit         cone_exp  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int         rr_exp    [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    req_valid = '0;
    req_vec   = '0;
    rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2.
    step(4'b0100, {5'd0, 5'b00111, 5'd0, 5'd0}, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    check("single_id",   32'(rsp_id),    32'd2);
    check("single_data", 32'(rsp_data),  32'd0);
    check("single_cnt",  32'(grant_cnt), 32'd1);
    step(4'b0000, '0, 1'b1);

    // Cone truth vectors through requester 0.
    foreach (cone_vecs[j]) begin
      step(4'b0001, {15'd0, cone_vecs[j]}, 1'b1);
      step(4'b0000, '0, 1'b1);
      step(4'b0000, '0, 1'b1);
      check("cone_data", 32'(rsp_data), 32'(cone_exp[j]));
    end

    // Fairness with everyone requesting from a fresh pointer.
    do_reset();
    grant_log.delete();
    grant_cyc.delete();
    repeat (18) step('1, rand_vec(), 1'b1);
    check("rr_count", 32'(grant_log.size()), 32'd6);
    if (grant_log.size() >= 6) begin
      for (int j = 0; j < 6; j++) check("rr_order", 32'(grant_log[j]), 32'(rr_exp[j]));
      for (int j = 1; j < 6; j++) check("rr_spacing", 32'(grant_cyc[j] - grant_cyc[j-1]), 32'd3);
    end

    // Backpressure: response held for 10 cycles, then released.
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b1000, {5'b11000, 15'd0}, 1'b0);
    step(4'b0000, '0, 1'b0);
    repeat (10) step('1, rand_vec(), 1'b0);
    step('1, rand_vec(), 1'b1);
    step('1, rand_vec(), 1'b1);
    check("bp_regrant", 32'(req_ready != '0), 32'd1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);
    step(4'b0000, '0, 1'b1);

    // Reset while requester 2's operand sits in EVAL.
    do_reset();
    step(4'b0100, {5'd0, 5'b00000, 5'd0, 5'd0}, 1'b1);
    step(4'b0000, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, rand_vec(), 1'b1);
    check("post_rst_grant", 32'(req_ready), 32'h2);
    repeat (4) step(4'b0000, '0, 1'b1);

    // Saturating counter: 20 grants into a 4-bit counter.
    do_reset();
    repeat (60) step('1, rand_vec(), 1'b1);
    check("sat_cnt", 32'(grant_cnt), 32'd15);
    repeat (6) step('1, rand_vec(), 1'b1);
    check("sat_hold", 32'(grant_cnt), 32'd15);

    // Random traffic with random backpressure.
    do_reset();
    repeat (400) step(N'($urandom()), rand_vec(), ($urandom_range(0, 3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cone_eval_arbiter.md
Name: cone_eval_arbiter

Overview:
- Shares one 5-input AOI evaluation cone between NUM_REQ requesters.
- Each requester hands in a 5-bit operand vector; a round-robin arbiter picks one request, registers it and evaluates the cone.
- The result is returned on a single valid/ready response channel, tagged with the requester id.
- Sits between the per-lane operand generators and the downstream result collector of the jpeg logic slice.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDW, $clog2(NUM_REQ) (min 1), width of requester id.
- CNTW, 16, width of the saturating grant counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_vec  input  NUM_REQ*5  operand vectors; requester i uses bits [5i+4:5i].
- req_ready  output  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_id  output  IDW  requester id of the result.
- rsp_data  output  1  cone result.
- busy  output  1  high in any state other than IDLE.
- grant_cnt  output  CNTW  total accepted requests, saturating.

Behaviour:
- Cone function, operand bits a0..a4 = vec[0]..vec[4]: y = ~((a0 & a1 & a2) | (a4 & ~a3)).
- FSM states IDLE, EVAL, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, grant_cnt=0, RR pointer=0, req_ready=0.
- Reset is asynchronous: asserting rst_n low at any point returns to IDLE immediately. An in-flight operand or result is discarded, with no response.
- IDLE:
  - req_ready is combinational. Exactly one bit is set, for the first requester with req_valid=1, searching from ptr upward with wrap modulo NUM_REQ.
  - If no request is valid, req_ready is all zeros.
  - On accept: capture vec and id, ptr <= winner+1 (wraps to 0 after NUM_REQ-1), grant_cnt increments unless already at all-ones, next state EVAL.
- EVAL:
  - req_ready=0.
  - The cone is computed from the registered operand into the rsp_data register; rsp_id is loaded.
  - Next state RESP.
- RESP:
  - rsp_valid=1. rsp_id and rsp_data are held stable until the handshake.
  - rsp_valid & rsp_ready: rsp_valid drops next cycle, next state IDLE.
  - rsp_ready low: stay in RESP indefinitely.
- Latency and throughput:
  - Accept on cycle t gives rsp_valid high at cycle t+2.
  - Minimum spacing between accepts is 3 cycles (with rsp_ready held high).
- req_ready is never asserted outside IDLE. Requesters that are not granted keep req_valid and vec stable; the block does not check this.
- A requester that drops req_valid before being granted is simply skipped. Nothing is latched for it.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0,...
- Any requester waits at most NUM_REQ-1 other grants.
- rsp_ready high outside RESP has no effect.
- Once saturated, grant_cnt holds at 2^CNTW-1.

Test Plan:
- Reset then single request: requester 2 presents vec=5'b00111 → req_ready=4'b0100 that cycle; two cycles later rsp_valid=1, rsp_id=2, rsp_data=0; grant_cnt=1.
- Cone truth check through requester 0, rsp_ready tied high: vec 5'b00000→1, 5'b10000→0, 5'b11000→1, 5'b00011→1, 5'b11111→0. Each result appears exactly 2 cycles after its accept.
- Round-robin: all four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1. Accepts occur on cycles t, t+3, t+6, ...
- Backpressure: rsp_ready held low 10 cycles in RESP → rsp_valid, rsp_id and rsp_data stable, req_ready=0 throughout. Releasing rsp_ready gives one handshake, then the next grant happens in IDLE on the following cycle.
- Reset mid-operation: rst_n pulsed low while in EVAL → rsp_valid never rises for that request. Outputs return to reset values asynchronously and ptr=0. Afterwards, with requesters 1 and 3 valid, requester 1 is granted first.
- Saturation: with CNTW=4, issue 20 requests → grant_cnt reaches 15 and stays at 15.
